// File: rtl/imm_narrow_16b_12b_pkg.sv
// Shared constants, FIFO entry layout and the 16b -> 12b narrowing rule.
package imm_narrow_16b_12b_pkg;

    localparam int unsigned IN_W    = 16;
    localparam int unsigned IMM12_W = 12;
    localparam int unsigned ENTRY_W = IMM12_W + 1;

    localparam logic [IMM12_W-1:0] IMM12_MAX = 12'h7FF;
    localparam logic [IMM12_W-1:0] IMM12_MIN = 12'h800;

    typedef struct packed {
        logic               ovf;
        logic [IMM12_W-1:0] data;
    } imm_entry_t;

    // Value fits iff the bits above the 12-bit sign bit replicate it.
    function automatic imm_entry_t narrow_imm(input logic [IN_W-1:0] v, input logic sat);
        imm_entry_t e;
        logic       fits;
        fits   = (v[IN_W-1:IMM12_W-1] == {(IN_W-IMM12_W+1){v[IN_W-1]}});
        e.ovf  = ~fits;
        e.data = v[IMM12_W-1:0];
        if (!fits && sat) begin
            e.data = v[IN_W-1] ? IMM12_MIN : IMM12_MAX;
        end
        return e;
    endfunction

endpackage

// File: rtl/imm_narrow_16b_12b_sync_fifo_ptr.sv
// Pointer-based synchronous FIFO with registered write-ready (not full) and read-valid (not empty).
module imm_narrow_16b_12b_sync_fifo_ptr #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             wr_ready,
    output logic             rd_valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic             push_ok, pop_ok;

    assign push_ok = push & wr_ready_q;
    assign pop_ok  = pop & rd_valid_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Ready/valid track the post-edge occupancy so no same-cycle pass-through exists.
        wr_ready_d = (count_d < CNT_W'(DEPTH));
        rd_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign wr_ready = wr_ready_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/imm_narrow_16b_12b.sv
// Narrows signed 16-bit values to 12-bit immediates, buffers {ovf, data} in a FIFO, counts overflows.
module imm_narrow_16b_12b
    import imm_narrow_16b_12b_pkg::*;
#(
    parameter bit          SATURATE   = 1'b1,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IMM12_W-1:0] out_data,
    output logic               out_ovf,
    input  logic               clr_count,
    output logic [CNT_W-1:0]   ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    imm_entry_t         in_entry_c;
    imm_entry_t         head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;

    assign in_entry_c = narrow_imm(in_data, SATURATE);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    imm_narrow_16b_12b_sync_fifo_ptr #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .wr_data  (in_entry_c),
        .rd_data  (head_bits),
        .wr_ready (in_ready),
        .rd_valid (out_valid)
    );

    assign head_entry = imm_entry_t'(head_bits);
    assign out_data   = head_entry.data;
    assign out_ovf    = head_entry.ovf;

    // Clear wins over a same-cycle overflow event; the count sticks at all-ones.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (clr_count) begin
            ovf_count_d = '0;
        end else if (push && in_entry_c.ovf && (ovf_count_q != CNT_MAX)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;

endmodule

// File: doc/imm_narrow_16b_12b.md
Name: imm_narrow_16b_12b

Overview:
- Inverse of the 12b-to-16b immediate sign extender.
- Takes 16-bit signed values, such as ALU results or PC offsets headed for a 12-bit immediate field, and narrows them to 12 bits.
- Flags values that do not fit and saturates or truncates them.
- Streams results through a small output FIFO with valid/ready handshakes on both sides. It sits between the datapath and the instruction/immediate packing logic.

Parameters:
- SATURATE, 1, 1 = clamp out-of-range values to 0x7FF/0x800; 0 = truncate to in_data[11:0]
- FIFO_DEPTH, 2, output buffer entries (power of 2, >= 2)
- CNT_W, 8, width of the saturating overflow event counter

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is presented
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  16  signed source value
- out_valid  output  1  FIFO head holds a result
- out_ready  input  1  consumer takes the head this cycle
- out_data  output  12  narrowed value at FIFO head
- out_ovf  output  1  head entry did not fit in 12 bits
- clr_count  input  1  synchronous clear of ovf_count
- ovf_count  output  CNT_W  number of accepted out-of-range inputs, saturating

Behaviour:
- Reset (reset_n low, asynchronous): FIFO emptied, pointers = 0, count = 0, out_valid = 0, out_data = 0, out_ovf = 0, ovf_count = 0, in_ready = 0 while reset_n is low. After release, in_ready = 1 from the first clk edge.
- Fit rule: a value fits iff in_data[15:11] are all equal, i.e. sign-extending in_data[11:0] reproduces in_data.
- Overflow direction is taken from in_data[15].
- Narrowing when the value fits: result = in_data[11:0], ovf = 0.
- Narrowing when it does not fit, SATURATE=1: positive -> 0x7FF, negative -> 0x800, ovf = 1.
- Narrowing when it does not fit, SATURATE=0: result = in_data[11:0], ovf = 1.
- Conversion is combinational at the input. The 13-bit {ovf, result} is written into the FIFO on acceptance.
- Accept (push) when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = (count < FIFO_DEPTH), registered-style. There is no pass-through when full: a same-cycle pop does not let a push in.
- Latency: input accepted at edge N is visible on out_valid/out_data at N+1 if the FIFO was empty.
- Throughput: 1 item per cycle.
- FIFO states: EMPTY (count=0, out_valid=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH, in_ready=0).
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged; the head advances and the tail writes.
  - Pop while EMPTY is impossible because out_valid=0. Push while FULL is impossible because in_ready=0.
- Pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
- out_data/out_ovf are stable while out_valid & !out_ready. Producer-side in_data changes while in_ready=0 are ignored.
- ovf_count increments by 1 on each accepted input with ovf=1 and holds at 2^CNT_W-1.
- clr_count has priority: in a cycle where clr_count=1 the counter becomes 0 and any same-cycle overflow event is not counted.
- Reset mid-operation: all buffered entries are discarded with no partial output. out_valid drops asynchronously.

Decomposition:
- Shared package/header holds:
  - IMM12_MAX = 12'h7FF, IMM12_MIN = 12'h800
  - the imm12 width constant
  - the FIFO entry layout {ovf, data[11:0]}
- One natural sub-module: sync_fifo_ptr, a parameterised width/depth FIFO with count, full and empty, reset_n async. The top level holds the narrowing logic and the counter.

Test Plan:
- SATURATE=1, out_ready=1, push 0x07FF, 0xF800, 0x0800, 0x8000, 0x0123 on consecutive cycles -> out_data 0x7FF/0, 0x800/0, 0x7FF/1, 0x800/1, 0x123/0 (data/ovf), each one cycle after acceptance; ovf_count=2.
- SATURATE=0: push 0x0800, 0xF7FF -> out_data 0x800 ovf=1, 0x7FF ovf=1; push 0xFFFF -> 0xFFF ovf=0.
- Backpressure, out_ready=0: offer 0x0001, 0x0002, 0x0003 -> first two accepted, in_ready=0 after the second, third held. Raise out_ready -> outputs 0x001, 0x002, 0x003 in order, no loss or duplication.
- Steady stream with count=1 and out_ready=1 -> simultaneous push/pop each cycle, count stays 1, 1 item/cycle for 16 cycles.
- Drive 300 out-of-range inputs -> ovf_count=255 (CNT_W=8). Then assert clr_count in the same cycle as an overflow acceptance -> ovf_count=0 next cycle.
- FIFO full (2 entries), pull reset_n low between edges -> out_valid=0 and in_ready=0 immediately. After release: empty, ovf_count=0, in_ready=1 at the first edge.
